// File: rtl/riscv_decode_exec_unit.sv
// riscv_decode_exec_unit
// Decode, register file and execute stage for an RV64I pipeline.
// Everything except the 32 x XLEN register file is combinational from
// i_instr, i_pc and the register contents.
//
// Ports
//   i_clk, i_rst                  rising-edge clock, async active-high reset
//   i_instr, i_pc                 instruction word and its address
//   i_wb_en, i_wb_addr, i_wb_data writeback port from the memory stage
//   o_alu_opr                     ALU operation code
//   o_load_opr, o_store_opr       load / store width (0 when not a load / store)
//   o_rd_addr, o_rs1_addr, o_rs2_addr  register fields of i_instr
//   o_reg_wr_en, o_mem_wr_en, o_mem_rd_en, o_br_en, o_rs2_en  decoded controls
//   o_rs1_data, o_rs2_data        register read data (write-first)
//   o_imm                         sign-extended immediate
//   o_alu_out                     ALU result
//   o_br_addr                     i_pc + o_imm
//   o_br_taken                    active-low redirect (0 = taken)
module riscv_decode_exec_unit #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [31:0]     i_instr,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_wb_en,
    input  logic [4:0]      i_wb_addr,
    input  logic [XLEN-1:0] i_wb_data,
    output logic [3:0]      o_alu_opr,
    output logic [2:0]      o_load_opr,
    output logic [1:0]      o_store_opr,
    output logic [4:0]      o_rd_addr,
    output logic [4:0]      o_rs1_addr,
    output logic [4:0]      o_rs2_addr,
    output logic            o_reg_wr_en,
    output logic            o_mem_wr_en,
    output logic            o_mem_rd_en,
    output logic            o_br_en,
    output logic            o_rs2_en,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data,
    output logic [XLEN-1:0] o_imm,
    output logic [XLEN-1:0] o_alu_out,
    output logic [XLEN-1:0] o_br_addr,
    output logic            o_br_taken
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_BEQ  = 4'b1000,
        ALU_BNE  = 4'b1001,
        ALU_BLT  = 4'b1010,
        ALU_JAL  = 4'b1011,
        ALU_BGE  = 4'b1100,
        ALU_SLT  = 4'b1101,
        ALU_SLTU = 4'b1110,
        ALU_NOP  = 4'b1111
    } alu_op_e;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [XLEN-1:0] r_regs [NREGS];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_wb_en && (i_wb_addr != 5'd0)) begin
            r_regs[i_wb_addr] <= i_wb_data;
        end
    end

    logic [4:0] w_rs1_addr;
    logic [4:0] w_rs2_addr;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;

    assign w_rs1_addr = i_instr[19:15];
    assign w_rs2_addr = i_instr[24:20];

    // Write-first bypass; suppressed during reset so reads stay 0 even if
    // the writeback port is active while reset is held.
    assign w_rs1_data = (i_rst || (w_rs1_addr == 5'd0)) ? '0 :
                        (i_wb_en && (i_wb_addr == w_rs1_addr)) ? i_wb_data :
                        r_regs[w_rs1_addr];
    assign w_rs2_data = (i_rst || (w_rs2_addr == 5'd0)) ? '0 :
                        (i_wb_en && (i_wb_addr == w_rs2_addr)) ? i_wb_data :
                        r_regs[w_rs2_addr];

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_j;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_imm_i  = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
    assign w_imm_s  = {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign w_imm_b  = {{(XLEN-13){i_instr[31]}}, i_instr[31], i_instr[7],
                       i_instr[30:25], i_instr[11:8], 1'b0};
    assign w_imm_j  = {{(XLEN-21){i_instr[31]}}, i_instr[31], i_instr[19:12],
                       i_instr[20], i_instr[30:21], 1'b0};

    // Shared R/I funct3 mapping; SUB only exists in the register form,
    // while bit 30 selects SRA for both forms.
    function automatic alu_op_e f_arith(input logic [2:0] f3, input logic b30,
                                        input logic is_r);
        alu_op_e op;
        case (f3)
            3'b000:  op = (is_r && b30) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = b30 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    alu_op_e         w_alu_op;
    logic [2:0]      w_load_opr;
    logic [1:0]      w_store_opr;
    logic            w_reg_wr_en;
    logic            w_mem_wr_en;
    logic            w_mem_rd_en;
    logic            w_br_en;
    logic            w_rs2_en;
    logic [XLEN-1:0] w_imm;

    always_comb begin
        w_alu_op    = ALU_NOP;
        w_load_opr  = 3'b000;
        w_store_opr = 2'b00;
        w_reg_wr_en = 1'b0;
        w_mem_wr_en = 1'b0;
        w_mem_rd_en = 1'b0;
        w_br_en     = 1'b0;
        w_rs2_en    = 1'b0;
        w_imm       = '0;
        case (w_opcode)
            OP_R: begin
                w_reg_wr_en = 1'b1;
                w_rs2_en    = 1'b1;
                w_alu_op    = f_arith(w_funct3, i_instr[30], 1'b1);
            end
            OP_I: begin
                w_reg_wr_en = 1'b1;
                w_imm       = w_imm_i;
                w_alu_op    = f_arith(w_funct3, i_instr[30], 1'b0);
            end
            OP_LOAD: begin
                w_reg_wr_en = 1'b1;
                w_mem_rd_en = 1'b1;
                w_imm       = w_imm_i;
                w_alu_op    = ALU_ADD;
                w_load_opr  = w_funct3;
            end
            OP_STORE: begin
                w_mem_wr_en = 1'b1;
                w_imm       = w_imm_s;
                w_alu_op    = ALU_ADD;
                w_store_opr = w_funct3[1:0];
            end
            OP_BRANCH: begin
                w_rs2_en = 1'b1;
                w_imm    = w_imm_b;
                w_br_en  = 1'b1;
                case (w_funct3)
                    3'b000: w_alu_op = ALU_BEQ;
                    3'b001: w_alu_op = ALU_BNE;
                    3'b100: w_alu_op = ALU_BLT;
                    3'b101: w_alu_op = ALU_BGE;
                    default: begin
                        w_alu_op = ALU_NOP;
                        w_br_en  = 1'b0;
                    end
                endcase
            end
            OP_JAL: begin
                w_reg_wr_en = 1'b1;
                w_br_en     = 1'b1;
                w_imm       = w_imm_j;
                w_alu_op    = ALU_JAL;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Execute
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b;
    logic [XLEN-1:0] w_diff;
    logic [SHW-1:0]  w_shamt;
    logic            w_slt;
    logic            w_sltu;
    logic [XLEN-1:0] w_alu_out;
    logic            w_br_taken;

    assign w_a     = w_rs1_data;
    assign w_b     = w_rs2_en ? w_rs2_data : w_imm;
    assign w_diff  = w_a - w_b;
    assign w_shamt = w_b[SHW-1:0];
    assign w_slt   = $signed(w_a) < $signed(w_b);
    assign w_sltu  = w_a < w_b;

    always_comb begin
        w_alu_out  = '0;
        w_br_taken = 1'b1;
        case (w_alu_op)
            ALU_ADD:  w_alu_out = w_a + w_b;
            ALU_SUB:  w_alu_out = w_diff;
            ALU_AND:  w_alu_out = w_a & w_b;
            ALU_OR:   w_alu_out = w_a | w_b;
            ALU_XOR:  w_alu_out = w_a ^ w_b;
            ALU_SLL:  w_alu_out = w_a << w_shamt;
            ALU_SRL:  w_alu_out = w_a >> w_shamt;
            ALU_SRA:  w_alu_out = $unsigned($signed(w_a) >>> w_shamt);
            ALU_SLT:  w_alu_out = {{(XLEN-1){1'b0}}, w_slt};
            ALU_SLTU: w_alu_out = {{(XLEN-1){1'b0}}, w_sltu};
            ALU_BEQ: begin
                w_alu_out  = w_diff;
                w_br_taken = !(w_a == w_b);
            end
            ALU_BNE: begin
                w_alu_out  = w_diff;
                w_br_taken = (w_a == w_b);
            end
            ALU_BLT: begin
                w_alu_out  = w_diff;
                w_br_taken = !w_slt;
            end
            ALU_BGE: begin
                w_alu_out  = w_diff;
                w_br_taken = w_slt;
            end
            ALU_JAL: begin
                w_alu_out  = i_pc + XLEN'(4);
                w_br_taken = 1'b0;
            end
            default: ;
        endcase
    end

    assign o_alu_opr   = w_alu_op;
    assign o_load_opr  = w_load_opr;
    assign o_store_opr = w_store_opr;
    assign o_rd_addr   = i_instr[11:7];
    assign o_rs1_addr  = w_rs1_addr;
    assign o_rs2_addr  = w_rs2_addr;
    assign o_reg_wr_en = w_reg_wr_en;
    assign o_mem_wr_en = w_mem_wr_en;
    assign o_mem_rd_en = w_mem_rd_en;
    assign o_br_en     = w_br_en;
    assign o_rs2_en    = w_rs2_en;
    assign o_rs1_data  = w_rs1_data;
    assign o_rs2_data  = w_rs2_data;
    assign o_imm       = w_imm;
    assign o_alu_out   = w_alu_out;
    assign o_br_addr   = i_pc + w_imm;
    assign o_br_taken  = w_br_taken;

endmodule

// File: tb/tb_riscv_decode_exec_unit.sv
// Self-checking bench for riscv_decode_exec_unit: directed scenarios plus
// randomized instructions compared against an instruction-level model.
module tb_riscv_decode_exec_unit;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic [63:0] pc;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic [3:0]  alu_opr;
    logic [2:0]  load_opr;
    logic [1:0]  store_opr;
    logic [4:0]  rd_addr, rs1_addr, rs2_addr;
    logic        reg_wr_en, mem_wr_en, mem_rd_en, br_en, rs2_en;
    logic [63:0] rs1_data, rs2_data, imm, alu_out, br_addr;
    logic        br_taken;

    int total = 0;
    int bad   = 0;

    logic [63:0] mregs [32];

    riscv_decode_exec_unit dut (
        .i_clk(clk), .i_rst(rst), .i_instr(instr), .i_pc(pc),
        .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
        .o_alu_opr(alu_opr), .o_load_opr(load_opr), .o_store_opr(store_opr),
        .o_rd_addr(rd_addr), .o_rs1_addr(rs1_addr), .o_rs2_addr(rs2_addr),
        .o_reg_wr_en(reg_wr_en), .o_mem_wr_en(mem_wr_en), .o_mem_rd_en(mem_rd_en),
        .o_br_en(br_en), .o_rs2_en(rs2_en),
        .o_rs1_data(rs1_data), .o_rs2_data(rs2_data), .o_imm(imm),
        .o_alu_out(alu_out), .o_br_addr(br_addr), .o_br_taken(br_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  opr;
        logic [2:0]  ld;
        logic [1:0]  st;
        logic        we, mwe, mre, bren, rs2en;
        logic [63:0] imm;
        logic [63:0] alu;
        logic [63:0] bra;
        logic        tk;
    } exp_t;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
            input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] rs1,
            input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {im, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] im, input logic [4:0] rs2,
            input logic [4:0] rs1, input logic [2:0] f3);
        return {im[11:5], rs2, rs1, f3, im[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [4:0] rs2,
            input logic [4:0] rs1, input logic [2:0] f3);
        return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] im, input logic [4:0] rd);
        return {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
    endfunction

    // Register read as seen by the model, including same-cycle writeback.
    function automatic logic [63:0] model_read(input logic [4:0] a);
        if (rst || a == 5'd0) return 64'd0;
        if (wb_en && wb_addr == a) return wb_data;
        return mregs[a];
    endfunction

    // Instruction-level reference: result of executing ins with operands a/rb.
    function automatic exp_t ref_model(input logic [31:0] ins, input logic [63:0] p,
            input logic [63:0] a, input logic [63:0] rb);
        exp_t e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [63:0] b;
        logic signed [63:0] sa, sb;
        int sh;
        e = '0;
        e.opr = 4'hF;
        e.tk = 1'b1;
        op = ins[6:0];
        f3 = ins[14:12];
        case (op)
            7'h13, 7'h03: e.imm = {{52{ins[31]}}, ins[31:20]};
            7'h23: e.imm = {{52{ins[31]}}, ins[31:25], ins[11:7]};
            7'h63: e.imm = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            7'h6F: e.imm = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: e.imm = 64'd0;
        endcase
        e.bra = p + e.imm;
        b = (op == 7'h33 || op == 7'h63) ? rb : e.imm;
        sa = a;
        sb = b;
        sh = int'(b[5:0]);
        if (op == 7'h33 || op == 7'h13) begin
            e.we = 1'b1;
            e.rs2en = (op == 7'h33);
            case (f3)
                3'd0: if (op == 7'h33 && ins[30]) begin e.opr = 4'h1; e.alu = a - b; end
                      else begin e.opr = 4'h0; e.alu = a + b; end
                3'd1: begin e.opr = 4'h5; e.alu = a << sh; end
                3'd2: begin e.opr = 4'hD; e.alu = (sa < sb) ? 64'd1 : 64'd0; end
                3'd3: begin e.opr = 4'hE; e.alu = (a < b) ? 64'd1 : 64'd0; end
                3'd4: begin e.opr = 4'h4; e.alu = a ^ b; end
                3'd5: if (ins[30]) begin e.opr = 4'h7; e.alu = sa >>> sh; end
                      else begin e.opr = 4'h6; e.alu = a >> sh; end
                3'd6: begin e.opr = 4'h3; e.alu = a | b; end
                default: begin e.opr = 4'h2; e.alu = a & b; end
            endcase
        end else if (op == 7'h03) begin
            e.we = 1'b1; e.mre = 1'b1; e.opr = 4'h0; e.ld = f3; e.alu = a + b;
        end else if (op == 7'h23) begin
            e.mwe = 1'b1; e.opr = 4'h0; e.st = f3[1:0]; e.alu = a + b;
        end else if (op == 7'h63) begin
            e.rs2en = 1'b1;
            case (f3)
                3'd0: begin e.bren = 1'b1; e.opr = 4'h8; e.alu = a - b; e.tk = !(a == b); end
                3'd1: begin e.bren = 1'b1; e.opr = 4'h9; e.alu = a - b; e.tk = (a == b); end
                3'd4: begin e.bren = 1'b1; e.opr = 4'hA; e.alu = a - b; e.tk = !(sa < sb); end
                3'd5: begin e.bren = 1'b1; e.opr = 4'hC; e.alu = a - b; e.tk = !(sa >= sb); end
                default: ;
            endcase
        end else if (op == 7'h6F) begin
            e.we = 1'b1; e.bren = 1'b1; e.opr = 4'hB; e.alu = p + 64'd4; e.tk = 1'b0;
        end
        return e;
    endfunction

    task automatic write_reg(input logic [4:0] a, input logic [63:0] d);
        wb_en = 1'b1;
        wb_addr = a;
        wb_data = d;
        @(posedge clk);
        #1;
        wb_en = 1'b0;
        if (a != 5'd0) mregs[a] = d;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        wb_en = 1'b0;
        wb_addr = 5'd0;
        wb_data = 64'd0;
        instr = 32'd0;
        pc = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
        instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
        #1;
        total++; if (rs1_data !== 64'd0) begin bad++; $display("FAIL rst_rs1 got=%h exp=0", rs1_data); end
        total++; if (rs2_data !== 64'd0) begin bad++; $display("FAIL rst_rs2 got=%h exp=0", rs2_data); end
        total++; if (alu_out !== 64'd0) begin bad++; $display("FAIL rst_alu got=%h exp=0", alu_out); end
        total++; if (reg_wr_en !== 1'b1) begin bad++; $display("FAIL rst_we got=%b exp=1", reg_wr_en); end
        total++; if (alu_opr !== 4'b0000) begin bad++; $display("FAIL rst_opr got=%b exp=0000", alu_opr); end
    endtask

    task automatic test_arith;
        write_reg(5'd1, 64'd5);
        write_reg(5'd2, 64'd9);
        instr = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd3);
        #1;
        total++; if (alu_out !== 64'hFFFFFFFFFFFFFFFC) begin bad++; $display("FAIL sub_alu got=%h exp=fffffffffffffffc", alu_out); end
        total++; if (alu_opr !== 4'b0001) begin bad++; $display("FAIL sub_opr got=%b exp=0001", alu_opr); end
        total++; if (rs2_en !== 1'b1) begin bad++; $display("FAIL sub_rs2en got=%b exp=1", rs2_en); end
        instr = enc_i(12'hFFF, 5'd0, 3'd0, 5'd4, 7'h13);
        #1;
        total++; if (imm !== 64'hFFFFFFFFFFFFFFFF) begin bad++; $display("FAIL addi_imm got=%h exp=ffffffffffffffff", imm); end
        total++; if (alu_out !== 64'hFFFFFFFFFFFFFFFF) begin bad++; $display("FAIL addi_alu got=%h exp=ffffffffffffffff", alu_out); end
        write_reg(5'd1, 64'h8000000000000000);
        instr = enc_i(12'h404, 5'd1, 3'd5, 5'd5, 7'h13);
        #1;
        total++; if (alu_out !== 64'hF800000000000000) begin bad++; $display("FAIL srai_alu got=%h exp=f800000000000000", alu_out); end
        total++; if (alu_opr !== 4'b0111) begin bad++; $display("FAIL srai_opr got=%b exp=0111", alu_opr); end
    endtask

    task automatic test_branch;
        write_reg(5'd1, 64'd7);
        write_reg(5'd2, 64'd7);
        pc = 64'h100;
        instr = enc_b(13'd16, 5'd2, 5'd1, 3'd0);
        #1;
        total++; if (br_en !== 1'b1) begin bad++; $display("FAIL beq_bren got=%b exp=1", br_en); end
        total++; if (br_taken !== 1'b0) begin bad++; $display("FAIL beq_taken got=%b exp=0", br_taken); end
        total++; if (br_addr !== 64'h110) begin bad++; $display("FAIL beq_addr got=%h exp=110", br_addr); end
        instr = enc_b(13'd16, 5'd2, 5'd1, 3'd1);
        #1;
        total++; if (br_taken !== 1'b1) begin bad++; $display("FAIL bne_taken got=%b exp=1", br_taken); end
        instr = enc_b(13'd16, 5'd2, 5'd1, 3'd2);
        #1;
        total++; if (br_en !== 1'b0 || alu_opr !== 4'hF || br_taken !== 1'b1) begin
            bad++; $display("FAIL badbr got=%b/%h/%b exp=0/f/1", br_en, alu_opr, br_taken);
        end
    endtask

    task automatic test_mem;
        instr = enc_i(12'd8, 5'd1, 3'd3, 5'd5, 7'h03);
        #1;
        total++; if (mem_rd_en !== 1'b1) begin bad++; $display("FAIL ld_mre got=%b exp=1", mem_rd_en); end
        total++; if (load_opr !== 3'b011) begin bad++; $display("FAIL ld_opr got=%b exp=011", load_opr); end
        total++; if (alu_out !== 64'd15) begin bad++; $display("FAIL ld_alu got=%h exp=f", alu_out); end
        instr = enc_s(12'd16, 5'd2, 5'd1, 3'd3);
        #1;
        total++; if (mem_wr_en !== 1'b1) begin bad++; $display("FAIL sd_mwe got=%b exp=1", mem_wr_en); end
        total++; if (store_opr !== 2'b11) begin bad++; $display("FAIL sd_opr got=%b exp=11", store_opr); end
        total++; if (reg_wr_en !== 1'b0) begin bad++; $display("FAIL sd_we got=%b exp=0", reg_wr_en); end
        total++; if (alu_out !== 64'd23) begin bad++; $display("FAIL sd_alu got=%h exp=17", alu_out); end
    endtask

    task automatic test_jal;
        pc = 64'h40;
        instr = enc_j(21'h1FFFF8, 5'd1);
        #1;
        total++; if (br_addr !== 64'h38) begin bad++; $display("FAIL jal_addr got=%h exp=38", br_addr); end
        total++; if (alu_out !== 64'h44) begin bad++; $display("FAIL jal_alu got=%h exp=44", alu_out); end
        total++; if (br_taken !== 1'b0) begin bad++; $display("FAIL jal_taken got=%b exp=0", br_taken); end
    endtask

    task automatic test_writeback;
        write_reg(5'd0, 64'hABCD);
        instr = enc_i(12'd0, 5'd0, 3'd0, 5'd1, 7'h13);
        wb_en = 1'b1; wb_addr = 5'd0; wb_data = 64'h1234;
        #1;
        total++; if (rs1_data !== 64'd0) begin bad++; $display("FAIL x0_read got=%h exp=0", rs1_data); end
        wb_en = 1'b0;
        write_reg(5'd7, 64'h1111);
        instr = enc_r(7'h00, 5'd7, 5'd7, 3'd0, 5'd8);
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 64'h2222;
        #1;
        total++; if (rs1_data !== 64'h2222) begin bad++; $display("FAIL bypass_rs1 got=%h exp=2222", rs1_data); end
        total++; if (alu_out !== 64'h4444) begin bad++; $display("FAIL bypass_alu got=%h exp=4444", alu_out); end
        @(posedge clk);
        #1;
        wb_en = 1'b0;
        mregs[7] = 64'h2222;
        #1;
        total++; if (rs2_data !== 64'h2222) begin bad++; $display("FAIL x7_commit got=%h exp=2222", rs2_data); end
    endtask

    task automatic test_async_reset;
        write_reg(5'd9, 64'hDEADBEEF00000001);
        instr = enc_i(12'd0, 5'd9, 3'd0, 5'd1, 7'h13);
        #1;
        total++; if (rs1_data !== 64'hDEADBEEF00000001) begin bad++; $display("FAIL pre_rst got=%h exp=deadbeef00000001", rs1_data); end
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 64'h77;
        #1;
        rst = 1'b1;
        #1;
        total++; if (rs1_data !== 64'd0) begin bad++; $display("FAIL async_rst got=%h exp=0", rs1_data); end
        @(posedge clk);
        #1;
        wb_en = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) mregs[i] = 64'd0;
        #1;
        total++; if (rs1_data !== 64'd0) begin bad++; $display("FAIL rst_discard got=%h exp=0", rs1_data); end
    endtask

    task automatic test_random;
        logic [6:0] ops [8];
        logic [31:0] r;
        logic [4:0] other;
        exp_t e;
        ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03; ops[3] = 7'h23;
        ops[4] = 7'h63; ops[5] = 7'h6F; ops[6] = 7'h37; ops[7] = 7'h00;
        for (int n = 0; n < 250; n++) begin
            wb_en = ($urandom_range(0, 1) == 1);
            wb_addr = 5'($urandom_range(0, 31));
            other = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0: wb_data = 64'($urandom_range(0, 15));
                1: wb_data = {$urandom(), $urandom()};
                2: wb_data = 64'h8000000000000000 | 64'($urandom_range(0, 255));
                default: wb_data = mregs[other];
            endcase
            r = $urandom();
            if ($urandom_range(0, 7) == 7) instr = r;
            else instr = {r[31:7], ops[$urandom_range(0, 6)]};
            if ($urandom_range(0, 3) == 0) instr[24:20] = instr[19:15];
            pc = {$urandom(), $urandom_range(0, 32'h3FFFFFFF), 2'b00};
            #1;
            e = ref_model(instr, pc, model_read(instr[19:15]), model_read(instr[24:20]));
            total++; if (alu_opr !== e.opr) begin bad++; $display("FAIL rnd_opr n=%0d ins=%h got=%h exp=%h", n, instr, alu_opr, e.opr); end
            total++; if (load_opr !== e.ld || store_opr !== e.st) begin bad++; $display("FAIL rnd_ldst n=%0d ins=%h got=%b/%b exp=%b/%b", n, instr, load_opr, store_opr, e.ld, e.st); end
            total++; if ({rd_addr, rs1_addr, rs2_addr} !== {instr[11:7], instr[19:15], instr[24:20]}) begin bad++; $display("FAIL rnd_addr n=%0d got=%h/%h/%h", n, rd_addr, rs1_addr, rs2_addr); end
            total++; if ({reg_wr_en, mem_wr_en, mem_rd_en, br_en, rs2_en} !== {e.we, e.mwe, e.mre, e.bren, e.rs2en}) begin
                bad++; $display("FAIL rnd_en n=%0d ins=%h got=%b exp=%b", n, instr, {reg_wr_en, mem_wr_en, mem_rd_en, br_en, rs2_en}, {e.we, e.mwe, e.mre, e.bren, e.rs2en});
            end
            total++; if (rs1_data !== model_read(instr[19:15])) begin bad++; $display("FAIL rnd_rs1 n=%0d got=%h exp=%h", n, rs1_data, model_read(instr[19:15])); end
            total++; if (rs2_data !== model_read(instr[24:20])) begin bad++; $display("FAIL rnd_rs2 n=%0d got=%h exp=%h", n, rs2_data, model_read(instr[24:20])); end
            total++; if (imm !== e.imm) begin bad++; $display("FAIL rnd_imm n=%0d ins=%h got=%h exp=%h", n, instr, imm, e.imm); end
            total++; if (alu_out !== e.alu) begin bad++; $display("FAIL rnd_alu n=%0d ins=%h got=%h exp=%h", n, instr, alu_out, e.alu); end
            total++; if (br_addr !== e.bra) begin bad++; $display("FAIL rnd_bra n=%0d ins=%h got=%h exp=%h", n, instr, br_addr, e.bra); end
            total++; if (br_taken !== e.tk) begin bad++; $display("FAIL rnd_tk n=%0d ins=%h got=%b exp=%b", n, instr, br_taken, e.tk); end
            @(posedge clk);
            if (wb_en && wb_addr != 5'd0) mregs[wb_addr] = wb_data;
            #1;
        end
        wb_en = 1'b0;
    endtask

    initial begin
        test_reset;
        test_arith;
        test_branch;
        test_mem;
        test_jal;
        test_writeback;
        test_async_reset;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
